seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, maximum pattern length in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  pattern request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port pattern  input  WIDTH  bits to send, MSB first.
REQ-007 SHALL have port len  input  $clog2(WIDTH)+1  number of bits to send, legal range 1..WIDTH.
REQ-008 SHALL have port out  output  1  serial data bit.
REQ-009 SHALL have port out_valid  output  1  out carries a pattern bit this cycle.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of a frame.
REQ-011 SHALL have port err  output  1  one-cycle pulse on an illegal len.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, SHIFT and GUARD; outputs depend on state and registers only.
REQ-013 In IDLE: in_ready=1, out=0, out_valid=0, done=0.
REQ-014 A handshake SHALL occur only when in_valid=1 and in_ready=1 on a rising edge.
REQ-015 On a handshake with len in 1..WIDTH: load pattern into the shift register, load bit counter with len, and go to SHIFT.
REQ-016 On a handshake with len=0 or len>WIDTH: discard the request, pulse err for the following cycle, and stay in IDLE.
REQ-017 In SHIFT: out=shift register MSB, out_valid=1, in_ready=0.
REQ-018 In SHIFT, each cycle: shift the register left by one with 0 fill and decrement the counter.
REQ-019 In SHIFT, when the counter equals 1, go to GUARD on that edge.
REQ-020 The first bit SHALL appear on out exactly one cycle after the handshake edge; a frame occupies exactly len cycles of out_valid=1.
REQ-021 In GUARD: out=0, out_valid=0, in_ready=0, done=1; go to IDLE unconditionally after one cycle.
REQ-022 Bits of pattern below position WIDTH-len SHALL never reach out.
REQ-023 in_valid, pattern and len SHALL be ignored outside IDLE; a held in_valid is accepted on the first IDLE cycle.
REQ-024 Minimum handshake-to-handshake spacing SHALL be len+2 cycles.
REQ-025 done and err SHALL never be asserted in the same cycle.

Reset
REQ-026 Asserting reset at any time, including mid-frame, SHALL immediately force state=IDLE, shift register=0, counter=0, out=0, out_valid=0, done=0, err=0, in_ready=1.
REQ-027 A frame interrupted by reset SHALL NOT resume, and done SHALL NOT pulse for it.
REQ-028 After reset deasserts, the block SHALL accept a handshake on the first rising edge.

Structure
REQ-029 The state enum (IDLE, SHIFT, GUARD) and the WIDTH default SHALL be defined in the shared package seq_pkg.
REQ-030 The loadable left-shift register with MSB tap SHALL be the sub-module seq_shift_reg (ports: clk, reset, load, shift, d[WIDTH], msb).
REQ-031 FSM, counter and output logic SHALL live in seq_pattern_tx.

Verification
REQ-032 Scenario: pattern=8'b1100_0000, len=2 -> out 1,1 with out_valid=1 on cycles +1 and +2, GUARD (out=0, done=1) on cycle +3, in_ready=1 on cycle +4.
REQ-033 Scenario: pattern=8'b1011_0111, len=8 -> out sequence 1,0,1,1,0,1,1,1, then one done pulse; total busy time 9 cycles.
REQ-034 Scenario: len=0, then len=9 -> err pulses once for each request, out_valid stays 0, state stays IDLE.
REQ-035 Scenario: in_valid held high continuously with len=1, pattern=8'h80 -> out pattern 1,0(guard) repeating, with a handshake every 3 cycles.
REQ-036 Scenario: reset asserted asynchronously after the 3rd bit of an 8-bit frame -> all outputs at reset values before the next edge, no done pulse, new frame accepted after release.
REQ-037 Scenario: pattern=8'b0111_1111, len=3 -> out 0,1,1; the low 5 bits never appear on out.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register; the MSB is the serial tap, zeros fill from the bottom.
module seq_shift_reg
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end else if (shift) begin
      data_d = data_q << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serialises a pattern of len bits MSB first, followed by a one-cycle guard slot
// that carries the done pulse. Illegal lengths are dropped and flagged on err.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [$clog2(WIDTH):0] len,
  output logic                   out,
  output logic                   out_valid,
  output logic                   done,
  output logic                   err
);

  localparam int LW = $clog2(WIDTH) + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(WIDTH);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  state_e          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            hs;
  logic            len_ok;
  logic            load;
  logic            shift_en;
  logic            msb;

  assign hs       = in_valid && (state_q == IDLE);
  assign len_ok   = (len != '0) && (len <= MAX_LEN);
  assign load     = hs && len_ok;
  assign shift_en = (state_q == SHIFT);

  seq_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift_en),
    .d     (pattern),
    .msb   (msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_ONE) state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter holds the bits still to be sent, including the one on out now.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = len;
    end else if (shift_en) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    err_d = hs && !len_ok;
  end

  // Leftover register bits are masked outside SHIFT so short frames never leak low bits.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SHIFT);
    out       = (state_q == SHIFT) && msb;
    done      = (state_q == GUARD);
    err       = err_q;
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench: expected bits queued at each accepted request, compared as they appear on out.
module tb_seq_pattern_tx;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       out;
  logic       out_valid;
  logic       done;
  logic       err;

  int n_tests;
  int n_fail;
  int exp_done;
  int exp_err;
  int done_seen;
  int err_seen;
  bit exp_q[$];

  seq_pattern_tx #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pattern   (pattern),
    .len       (len),
    .out       (out),
    .out_valid (out_valid),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare serial bits against the scoreboard and tally done/err pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          check("bit", out, exp_q.pop_front());
        end
        check("ready_while_busy", in_ready, 0);
      end else begin
        check("out_idle_zero", out, 0);
      end
      check("done_err_excl", done & err, 0);
      if (done) done_seen++;
      if (err) err_seen++;
    end
  end

  // Presents a request, waits (bounded) for acceptance, returns 1 ns after the handshake edge.
  task automatic send(input logic [7:0] p, input logic [3:0] l, output int waited);
    waited = 0;
    in_valid = 1'b1;
    pattern  = p;
    len      = l;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check("handshake_timeout", 0, 1);
    if (l >= 1 && l <= 8) begin
      for (int i = 0; i < l; i++) exp_q.push_back(p[7-i]);
      exp_done++;
    end else begin
      exp_err++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (!in_ready && busy < 40) begin
      busy++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int busy;
    int hs_cnt;
    int last_hs;
    logic [7:0] rp;
    logic [3:0] rl;

    n_tests = 0; n_fail = 0; exp_done = 0; exp_err = 0; done_seen = 0; err_seen = 0;
    reset = 1'b1; in_valid = 1'b0; pattern = '0; len = '0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Two-bit frame with exact latency checks; accepted on the first edge after reset.
    send(8'b1100_0000, 4'd2, w);
    check("first_edge_accept", w, 0);
    check("l2_c1_valid", out_valid, 1);
    check("l2_c1_out", out, 1);
    @(posedge clk); #1;
    check("l2_c2_valid", out_valid, 1);
    check("l2_c2_out", out, 1);
    @(posedge clk); #1;
    check("l2_c3_done", done, 1);
    check("l2_c3_valid", out_valid, 0);
    check("l2_c3_out", out, 0);
    check("l2_c3_ready", in_ready, 0);
    @(posedge clk); #1;
    check("l2_c4_ready", in_ready, 1);
    check("l2_c4_done", done, 0);

    // Full-width frame: busy for exactly 9 cycles.
    send(8'b1011_0111, 4'd8, w);
    wait_idle(busy);
    check("l8_busy", busy, 9);

    // Illegal lengths: err for one cycle each, no frame.
    send(8'hAA, 4'd0, w);
    check("len0_err", err, 1);
    check("len0_ready", in_ready, 1);
    check("len0_valid", out_valid, 0);
    @(posedge clk); #1;
    check("len0_err_clear", err, 0);
    send(8'hAA, 4'd9, w);
    check("len9_err", err, 1);
    check("len9_ready", in_ready, 1);
    @(posedge clk); #1;
    check("len9_err_clear", err, 0);

    // Held in_valid with len=1: handshake every 3 cycles.
    in_valid = 1'b1; pattern = 8'h80; len = 4'd1;
    hs_cnt = 0; last_hs = -3;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) begin
        exp_q.push_back(1'b1);
        exp_done++;
        check("held_gap", i - last_hs, 3);
        last_hs = i;
        hs_cnt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("held_hs_count", hs_cnt, 4);
    wait_idle(busy);

    // Reset mid-frame after the third bit.
    send(8'b1010_1010, 4'd8, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_out", out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_left", exp_q.size(), 5);
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_ready", in_ready, 1);
    send(8'b1100_1010, 4'd4, w);
    check("post_rst_accept", w, 0);
    wait_idle(busy);
    check("post_rst_busy", busy, 5);

    // Short frame whose low bits must stay hidden.
    send(8'b0111_1111, 4'd3, w);
    check("l3_first_bit", out, 0);
    wait_idle(busy);
    check("l3_busy", busy, 4);

    // Random back-to-back requests, some illegal.
    for (int k = 0; k < 8; k++) begin
      rp = 8'($urandom);
      rl = 4'($urandom_range(0, 10));
      send(rp, rl, w);
    end
    wait_idle(busy);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_seen, exp_done);
    check("err_count", err_seen, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
